// File: rtl/arb_rr_hold_pkg.sv
// Shared types and the round-robin selection helper for the hold-until-done arbiter.
// Supports up to ARB_N_MAX requesters.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned ARB_N_MAX = 32;
  localparam int unsigned ARB_IDX_W = $clog2(ARB_N_MAX);

  typedef struct packed {
    logic        vld;
    logic [31:0] idx;
  } pick_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rotate so that ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  function automatic pick_t rr_pick(input logic [ARB_N_MAX-1:0] req,
                                    input int unsigned ptr,
                                    input int unsigned n);
    logic [ARB_N_MAX-1:0] mask;
    logic [ARB_N_MAX-1:0] rot;
    pick_t                p;
    mask = '1 >> (ARB_N_MAX - n);
    rot  = ((req >> ptr) | (req << (n - ptr))) & mask;
    p    = '0;
    for (int unsigned i = 0; i < ARB_N_MAX; i++) begin
      if (!p.vld && rot[ARB_IDX_W'(i)]) begin
        p.vld = 1'b1;
        p.idx = (i + ptr) % n;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb_rr_hold_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arb_rr_hold_if
  import arb_pkg::*;
#(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = idx_w(N);

  logic [N-1:0]  i_req;
  logic          i_done;
  logic          o_gnt_vld;
  logic [IW-1:0] o_gnt_idx;
  logic [N-1:0]  o_gnt;
  logic          o_timeout;

  modport master (
    output i_req, i_done,
    input  o_gnt_vld, o_gnt_idx, o_gnt, o_timeout
  );

  modport slave (
    input  i_req, i_done,
    output o_gnt_vld, o_gnt_idx, o_gnt, o_timeout
  );
endinterface

// File: rtl/arb_rr_hold_dec.sv
// Binary index to one-hot decoder; indices >= N decode to all-zero.
module arb_rr_hold_dec #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [IW-1:0] i_idx,
  output logic [N-1:0]  o_onehot
);
  always_comb begin
    o_onehot = {{(N-1){1'b0}}, 1'b1} << i_idx;
  end
endmodule

// File: rtl/arb_rr_hold.sv
// Round-robin arbiter whose grant is held until the owner signals done or the
// optional watchdog expires; release re-arbitrates in the same cycle.
module arb_rr_hold
  import arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  arb_rr_hold_if.slave bus
);
  localparam int unsigned IW = idx_w(N);

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic          r_vld;
  logic [N-1:0]  r_gnt;
  logic          r_timeout;

  logic          w_wd_fire;
  logic          w_release;
  logic          w_grant;
  logic [IW-1:0] w_ptr_adv;
  logic [IW-1:0] w_arb_ptr;
  logic [IW-1:0] w_nxt_idx;
  logic [N-1:0]  w_nxt_gnt;
  pick_t         w_pick;

  // On release the search starts just past the current owner, so it ranks last.
  always_comb begin
    w_ptr_adv = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
    w_release = (r_state == BUSY) && (bus.i_done || w_wd_fire);
    w_arb_ptr = (r_state == BUSY) ? w_ptr_adv : r_ptr;
    w_pick    = rr_pick(ARB_N_MAX'(bus.i_req), 32'(w_arb_ptr), N);
    w_nxt_idx = IW'(w_pick.idx);
    w_grant   = w_pick.vld && ((r_state == IDLE) || w_release);
  end

  arb_rr_hold_dec #(
    .N  (N),
    .IW (IW)
  ) u_dec (
    .i_idx    (w_nxt_idx),
    .o_onehot (w_nxt_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_vld     <= 1'b0;
      r_gnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= BUSY;
            r_idx   <= w_nxt_idx;
            r_vld   <= 1'b1;
            r_gnt   <= w_nxt_gnt;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_ptr     <= w_ptr_adv;
            r_timeout <= w_wd_fire;
            if (w_grant) begin
              r_idx <= w_nxt_idx;
              r_vld <= 1'b1;
              r_gnt <= w_nxt_gnt;
            end else begin
              r_state <= IDLE;
              r_vld   <= 1'b0;
              r_gnt   <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Watchdog: i_done has priority, so the fire condition excludes it.
  if (TIMEOUT > 0) begin : g_wd
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wd_cnt <= '0;
      end else if (w_grant) begin
        r_wd_cnt <= '0;
      end else if ((r_state == BUSY) && !bus.i_done) begin
        r_wd_cnt <= r_wd_cnt + CW'(1);
      end
    end

    assign w_wd_fire = (r_state == BUSY) && !bus.i_done && (r_wd_cnt == CW'(TIMEOUT - 1));
  end else begin : g_no_wd
    assign w_wd_fire = 1'b0;
  end

  assign bus.o_gnt_vld = r_vld;
  assign bus.o_gnt_idx = r_idx;
  assign bus.o_gnt     = r_gnt;
  assign bus.o_timeout = r_timeout;

endmodule
